test_pattern_gen: RTL and testbench
===================================

# test_pattern_gen

Parametrised video test-pattern source that drives the `red`/`green`/`blue` inputs of the `hdmi` core from its `hpos`/`vpos`/blanking outputs. It generalises the fixed red-over-blue split into five selectable patterns: split, colour bars, scrolling checkerboard, greyscale gradient and solid. The active pattern advances on a button pulse or on a dwell timer, always at a frame boundary. It sits between the `hdmi` core and the board top level, replacing ad-hoc colour logic in the top module.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `POS_WIDTH`, 10: width of `hpos`/`vpos`.
- `COLOR_WIDTH`, 8: bits per colour channel; must be ≤ `POS_WIDTH`.
- `SPLIT_ROW`, 250: first row drawn blue in split mode.
- `CHECK_SHIFT`, 5: checker square size is 2^`CHECK_SHIFT` pixels.
- `DWELL_CYCLES`, 13500000: clocks per pattern in auto-cycle; must be ≥ 1.

Ports:
- `clk` input 1: pixel clock, the only clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `hpos` input `POS_WIDTH`: current pixel column from `hdmi`.
- `vpos` input `POS_WIDTH`: current row from `hdmi`.
- `in_hblank` input 1: horizontal blanking flag.
- `in_vblank` input 1: vertical blanking flag.
- `next_mode` input 1: single-cycle, already-debounced pulse requesting the next pattern.
- `solid_rgb` input 3×`COLOR_WIDTH`: {R,G,B} colour for solid mode. Sampled every cycle.
- `red`, `green`, `blue` output `COLOR_WIDTH` each: registered pixel colour.
- `mode` output 3: active pattern index, for LEDs.
- `frame_count` output 8: frame counter, wraps 255→0.

## Operation
- Modes (`mode`):
  - 0 SPLIT: red = max, green = blue = 0 when `vpos < SPLIT_ROW`; otherwise blue = max, red = green = 0.
  - 1 BARS: 8 bars, each `H_ACTIVE/8` px wide, selected by comparing `hpos` against constant boundaries. No divider. Left to right: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
  - 2 CHECKER: white when `((hpos + frame_count) >> CHECK_SHIFT) ^ (vpos >> CHECK_SHIFT)` has LSB 1, else black. The addition is `POS_WIDTH` bits with wrap.
  - 3 GRADIENT: R = G = B = `hpos[POS_WIDTH-1 -: COLOR_WIDTH]`. At default widths `hpos=639` gives 159.
  - 4 SOLID: output = `solid_rgb`.
- Modes 5–7 are never entered. Mode wraps 4→0.
- Blanking: when `in_hblank | in_vblank`, all colour channels are 0 regardless of mode.
- Frame boundary: the rising edge of `in_vblank`, detected against a registered copy. On that cycle, `frame_count` increments.
- Mode-change request: a `pending` flag is set by `next_mode` or by dwell expiry. It is applied at the next frame boundary: `mode` advances by exactly one, and `pending` clears. Multiple requests within one frame coalesce into a single advance.
- Simultaneous events:
  - `next_mode` and dwell expiry in the same cycle produce one request.
  - A request arriving on the frame-boundary cycle itself is applied at that boundary.
- Dwell timer counts every clock from 0 to `DWELL_CYCLES-1`. Expiry raises a request and reloads the count to 0. `next_mode` also resets the count to 0, giving a full dwell after a manual change.
- Reset mid-frame: all state returns to reset values immediately. The next rising edge of `in_vblank` is treated as a normal frame boundary.

## Timing
- Reset values:
  - `red`, `green`, `blue`: 0
  - `mode`: 0
  - `frame_count`: 0
  - `pending`: 0
  - dwell count: 0
  - vblank-edge register: 1, which suppresses a false edge when reset is released during vblank.
- Latency: one clock. Colour registered at edge N reflects `hpos`/`vpos`/blank sampled at edge N.
- `mode` and `frame_count` update on the clock edge where the vblank rising edge is detected. Both are stable through all active video.
- Pattern arithmetic uses `frame_count` and `mode` as registered at that edge.

## Configuration
- `TEST_PATTERN_AUTO_CYCLE_EN`:
  - Defined: the dwell timer is instantiated, and expiry raises mode-change requests.
  - Undefined: no timer logic is instantiated, and only `next_mode` changes the pattern. `DWELL_CYCLES` is ignored.

## Structure
- `test_pattern_pkg` holds:
  - mode constants `MODE_SPLIT` … `MODE_SOLID` and `NUM_MODES = 5`;
  - the 8-entry 3-bit bar colour table {R,G,B}.
- One sub-module, `dwell_timer`:
  - parameter `CYCLES`;
  - ports `clk`, `reset_n`, `restart`, `expire` (one-cycle pulse).
  - It is instantiated only under `TEST_PATTERN_AUTO_CYCLE_EN`.

## Test plan
Bench uses `H_ACTIVE=640`, `V_ACTIVE=480`, and a reduced `DWELL_CYCLES=1000` for the auto-cycle build.
- Reset, mode 0, scan (`hpos`=10, `vpos`=249) then (`hpos`=10, `vpos`=250) → RGB (255,0,0), then (0,0,255) one clock later. With blank high → (0,0,0).
- Mode 1, `hpos` = 79, 80, 639 → white, yellow, black.
- `next_mode` pulsed twice within one frame → `mode` goes 0→1 only, at the next `in_vblank` rising edge; unchanged before that edge.
- Mode 2, `CHECK_SHIFT=5`, `frame_count`=0: (`hpos`=31, `vpos`=0) black, (`hpos`=32, `vpos`=0) white. After one frame (`frame_count`=1), `hpos`=31 → white.
- Mode 4→`next_mode`→boundary → mode 0. `frame_count` 255 → boundary → 0.
- Auto-cycle build, no button → mode advances once per boundary after 1000 clocks. `next_mode` at clock 900 restarts the dwell. `reset_n` asserted mid-frame → all outputs 0 immediately.

Source files
------------

// File: rtl/test_pattern_pkg.sv
// Shared mode encodings, bar colour table and mode sequencing for the test-pattern source.
package test_pattern_pkg;

  localparam logic [2:0] MODE_SPLIT    = 3'd0;
  localparam logic [2:0] MODE_BARS     = 3'd1;
  localparam logic [2:0] MODE_CHECKER  = 3'd2;
  localparam logic [2:0] MODE_GRADIENT = 3'd3;
  localparam logic [2:0] MODE_SOLID    = 3'd4;
  localparam int         NUM_MODES     = 5;

  // {R,G,B} per bar, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [0:7][2:0] BAR_RGB = {3'b111, 3'b110, 3'b011, 3'b010,
                                         3'b101, 3'b100, 3'b001, 3'b000};

  function automatic logic [2:0] mode_after(input logic [2:0] m);
    return (m >= 3'(NUM_MODES - 1)) ? MODE_SPLIT : m + 3'd1;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter 0..CYCLES-1; expire pulses for one clock on the last count.
// restart reloads the count to 0 so a full dwell follows.
module dwell_timer #(
  parameter int CYCLES = 13500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic expire
);

  localparam int            CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (restart || expire) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Five-mode video test pattern, one-clock registered colour, modes advance only at vblank rise.
// Auto-cycling dwell timer is built only when TEST_PATTERN_AUTO_CYCLE_EN is defined.
module test_pattern_gen
  import test_pattern_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int POS_WIDTH    = 10,
  parameter int COLOR_WIDTH  = 8,
  parameter int SPLIT_ROW    = 250,
  parameter int CHECK_SHIFT  = 5,
  parameter int DWELL_CYCLES = 13500000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [POS_WIDTH-1:0]     hpos,
  input  logic [POS_WIDTH-1:0]     vpos,
  input  logic                     in_hblank,
  input  logic                     in_vblank,
  input  logic                     next_mode,
  input  logic [3*COLOR_WIDTH-1:0] solid_rgb,
  output logic [COLOR_WIDTH-1:0]   red,
  output logic [COLOR_WIDTH-1:0]   green,
  output logic [COLOR_WIDTH-1:0]   blue,
  output logic [2:0]               mode,
  output logic [7:0]               frame_count
);

  localparam int                     BAR_W = H_ACTIVE / 8;
  localparam logic [COLOR_WIDTH-1:0] CMAX  = '1;

  logic vblank_q;
  logic frame_edge;
  logic pending;
  logic expire;
  logic req;
  logic unused_cfg;

  assign unused_cfg = (V_ACTIVE < 0) | (DWELL_CYCLES < 1);

`ifdef TEST_PATTERN_AUTO_CYCLE_EN
  dwell_timer #(
    .CYCLES (DWELL_CYCLES)
  ) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (next_mode),
    .expire  (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign frame_edge = in_vblank & ~vblank_q;
  assign req        = next_mode | expire;

  // A request landing on the boundary cycle is folded into that boundary's advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q    <= 1'b1;
      pending     <= 1'b0;
      mode        <= MODE_SPLIT;
      frame_count <= 8'd0;
    end else begin
      vblank_q <= in_vblank;
      if (frame_edge) begin
        frame_count <= frame_count + 8'd1;
        if (pending || req) begin
          mode <= mode_after(mode);
        end
        pending <= 1'b0;
      end else if (req) begin
        pending <= 1'b1;
      end
    end
  end

  logic [2:0]             bar_idx;
  logic                   check_bit;
  logic [COLOR_WIDTH-1:0] r_n;
  logic [COLOR_WIDTH-1:0] g_n;
  logic [COLOR_WIDTH-1:0] b_n;

  always_comb begin
    r_n     = '0;
    g_n     = '0;
    b_n     = '0;
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hpos >= POS_WIDTH'(k * BAR_W)) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
    // Sum is kept at POS_WIDTH bits so the scroll wraps with the position counters.
    check_bit = |((((hpos + POS_WIDTH'(frame_count)) >> CHECK_SHIFT) ^ (vpos >> CHECK_SHIFT))
                  & POS_WIDTH'(1));
    case (mode)
      MODE_SPLIT: begin
        if (vpos < POS_WIDTH'(SPLIT_ROW)) begin
          r_n = CMAX;
        end else begin
          b_n = CMAX;
        end
      end
      MODE_BARS: begin
        r_n = {COLOR_WIDTH{BAR_RGB[bar_idx][2]}};
        g_n = {COLOR_WIDTH{BAR_RGB[bar_idx][1]}};
        b_n = {COLOR_WIDTH{BAR_RGB[bar_idx][0]}};
      end
      MODE_CHECKER: begin
        r_n = {COLOR_WIDTH{check_bit}};
        g_n = {COLOR_WIDTH{check_bit}};
        b_n = {COLOR_WIDTH{check_bit}};
      end
      MODE_GRADIENT: begin
        r_n = hpos[POS_WIDTH-1 -: COLOR_WIDTH];
        g_n = hpos[POS_WIDTH-1 -: COLOR_WIDTH];
        b_n = hpos[POS_WIDTH-1 -: COLOR_WIDTH];
      end
      MODE_SOLID: begin
        r_n = solid_rgb[3*COLOR_WIDTH-1 -: COLOR_WIDTH];
        g_n = solid_rgb[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
        b_n = solid_rgb[COLOR_WIDTH-1:0];
      end
      default: begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (in_hblank || in_vblank) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= r_n;
      green <= g_n;
      blue  <= b_n;
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen; auto-cycle checks run when TEST_PATTERN_AUTO_CYCLE_EN is defined.
module tb_test_pattern_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        in_hblank;
  logic        in_vblank;
  logic        next_mode;
  logic [23:0] solid_rgb;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic [2:0]  mode;
  logic [7:0]  frame_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  test_pattern_gen #(
    .H_ACTIVE     (640),
    .V_ACTIVE     (480),
    .POS_WIDTH    (10),
    .COLOR_WIDTH  (8),
    .SPLIT_ROW    (250),
    .CHECK_SHIFT  (5),
    .DWELL_CYCLES (1000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hpos        (hpos),
    .vpos        (vpos),
    .in_hblank   (in_hblank),
    .in_vblank   (in_vblank),
    .next_mode   (next_mode),
    .solid_rgb   (solid_rgb),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .mode        (mode),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, red, green, blue};
  endfunction

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic hb);
    @(negedge clk);
    hpos      = h;
    vpos      = v;
    in_hblank = hb;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    @(negedge clk);
    next_mode = 1'b1;
    @(negedge clk);
    next_mode = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    in_vblank = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    in_vblank = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check({tag, "_rgb"},  rgb(), 32'h0);
    check({tag, "_mode"}, {29'd0, mode}, 32'd0);
    check({tag, "_fc"},   {24'd0, frame_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    hpos      = '0;
    vpos      = '0;
    in_hblank = 1'b0;
    in_vblank = 1'b0;
    next_mode = 1'b0;
    solid_rgb = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb",  rgb(), 32'h0);
    check("rst_mode", {29'd0, mode}, 32'd0);
    check("rst_fc",   {24'd0, frame_count}, 32'd0);

`ifdef TEST_PATTERN_AUTO_CYCLE_EN
    begin
      int t0;
      @(negedge clk);
      reset_n = 1'b1;
      t0 = cyc;
      wait_cyc(t0 + 500);
      frame();
      check("auto_early", {29'd0, mode}, 32'd0);
      wait_cyc(t0 + 1100);
      frame();
      check("auto_first", {29'd0, mode}, 32'd1);
      wait_cyc(t0 + 1900);
      pulse();
      wait_cyc(t0 + 1950);
      frame();
      check("auto_manual", {29'd0, mode}, 32'd2);
      wait_cyc(t0 + 2500);
      frame();
      check("auto_restart", {29'd0, mode}, 32'd2);
      wait_cyc(t0 + 3000);
      frame();
      check("auto_after_restart", {29'd0, mode}, 32'd3);
      pix(10'd639, 10'd0, 1'b0);
      check("auto_grad", rgb(), 32'h9F9F9F);
      reset_check("auto_midrst");
    end
`else
    @(negedge clk);
    reset_n = 1'b1;

    pix(10'd10, 10'd249, 1'b0);
    check("split_top", rgb(), 32'hFF0000);
    pix(10'd10, 10'd250, 1'b0);
    check("split_bot", rgb(), 32'h0000FF);
    pix(10'd10, 10'd250, 1'b1);
    check("hblank", rgb(), 32'h0);

    pulse();
    pulse();
    pix(10'd10, 10'd10, 1'b0);
    check("mode_before_edge", {29'd0, mode}, 32'd0);
    frame();
    check("coalesce_mode", {29'd0, mode}, 32'd1);
    check("fc_1", {24'd0, frame_count}, 32'd1);

    pix(10'd79, 10'd0, 1'b0);
    check("bar_79", rgb(), 32'hFFFFFF);
    pix(10'd80, 10'd0, 1'b0);
    check("bar_80", rgb(), 32'hFFFF00);
    pix(10'd320, 10'd0, 1'b0);
    check("bar_320", rgb(), 32'hFF00FF);
    pix(10'd639, 10'd0, 1'b0);
    check("bar_639", rgb(), 32'h000000);

    pulse();
    frame();
    check("mode_chk", {29'd0, mode}, 32'd2);
    pix(10'd29, 10'd0, 1'b0);
    check("chk_fc2_h29", rgb(), 32'h000000);
    pix(10'd30, 10'd0, 1'b0);
    check("chk_fc2_h30", rgb(), 32'hFFFFFF);
    frame();
    pix(10'd29, 10'd0, 1'b0);
    check("chk_fc3_h29", rgb(), 32'hFFFFFF);
    pix(10'd29, 10'd32, 1'b0);
    check("chk_fc3_v32", rgb(), 32'h000000);

    pulse();
    frame();
    check("mode_grad", {29'd0, mode}, 32'd3);
    pix(10'd639, 10'd0, 1'b0);
    check("grad_639", rgb(), 32'h9F9F9F);
    pix(10'd32, 10'd0, 1'b0);
    check("grad_32", rgb(), 32'h080808);

    pulse();
    frame();
    check("mode_solid", {29'd0, mode}, 32'd4);
    pix(10'd5, 10'd5, 1'b0);
    check("solid_a", rgb(), 32'h123456);
    solid_rgb = 24'hABCDEF;
    pix(10'd6, 10'd5, 1'b0);
    check("solid_b", rgb(), 32'hABCDEF);
    frame();
    check("vblank_black", rgb(), 32'h0);
    check("fc_6", {24'd0, frame_count}, 32'd6);

    pulse();
    frame();
    check("mode_wrap", {29'd0, mode}, 32'd0);

    @(negedge clk);
    in_vblank = 1'b1;
    next_mode = 1'b1;
    @(posedge clk);
    #1;
    check("req_on_edge", {29'd0, mode}, 32'd1);
    @(negedge clk);
    in_vblank = 1'b0;
    next_mode = 1'b0;
    frame();
    check("no_stale_req", {29'd0, mode}, 32'd1);
    check("fc_9", {24'd0, frame_count}, 32'd9);

    pix(10'd79, 10'd0, 1'b0);
    check("pre_rst_bar", rgb(), 32'hFFFFFF);
    reset_check("midrst");

    repeat (255) frame();
    check("fc_255", {24'd0, frame_count}, 32'd255);
    frame();
    check("fc_wrap", {24'd0, frame_count}, 32'd0);
    check("mode_idle", {29'd0, mode}, 32'd0);

    @(negedge clk);
    in_vblank = 1'b1;
    reset_n   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    in_vblank = 1'b0;
    @(posedge clk);
    #1;
    check("no_false_edge", {24'd0, frame_count}, 32'd0);
    frame();
    check("edge_after_rst", {24'd0, frame_count}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
